scroll_msg_writer: RTL

- Writer side of the seven-segment text scroller path. Operator composes a message on the board: a character code set on SW, then KEY presses to append, delete or clear.
- Characters are stored in a small message buffer. The scroller display logic reads the buffer through a registered random-access read port.
- An update pulse tells the reader the message content changed.

---
 rtl/scroll_msg_writer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/scroll_msg_writer.sv
// Message buffer writer for the 7-seg scroller: debounced keys append/delete/clear chars; build option SCROLL_MSG_WRAP_EN.
// Latency: action 1 cycle after debounced press (msg_upd/overflow next cycle); rd_data 1 cycle after rd_addr.
// Backpressure: none; append when full is dropped with overflow, or overwrites the oldest char with SCROLL_MSG_WRAP_EN.
module scroll_msg_writer #(
    parameter int DEPTH     = 16,
    parameter int CODE_W    = 6,
    parameter int DB_CYCLES = 250000
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET_N,
    input  logic [CODE_W-1:0]        char_code,
    input  logic                     key_append_n,
    input  logic                     key_delete_n,
    input  logic                     key_clear_n,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [CODE_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   msg_len,
    output logic                     empty,
    output logic                     full,
    output logic                     msg_upd,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES - 1);
    localparam logic [AW:0]   LEN_FULL = (AW+1)'(DEPTH);

    // Key index 0 = append, 1 = delete, 2 = clear.
    logic [2:0]    key_raw;
    logic [2:0]    s1_q, s2_q, stb_q, stb_d, arm_q, arm_d, press;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    assign key_raw = {key_clear_n, key_delete_n, key_append_n};

    // A key is armed only after a debounced release, so a press held through reset never acts.
    always_comb begin
        stb_d = stb_q;
        arm_d = arm_q;
        press = '0;
        for (int k = 0; k < 3; k++) begin
            cnt_d[k] = '0;
            if (s2_q[k] != stb_q[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    stb_d[k] = s2_q[k];
                    press[k] = arm_q[k] & ~s2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end else if (!arm_q[k] && stb_q[k]) begin
                if (cnt_q[k] == CNT_MAX) arm_d[k] = 1'b1;
                else                     cnt_d[k] = cnt_q[k] + CW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            s1_q  <= '1;
            s2_q  <= '1;
            stb_q <= '1;
            arm_q <= '0;
            for (int k = 0; k < 3; k++) cnt_q[k] <= '0;
        end else begin
            s1_q  <= key_raw;
            s2_q  <= s1_q;
            stb_q <= stb_d;
            arm_q <= arm_d;
            cnt_q <= cnt_d;
        end
    end

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW:0]       len_q, len_d;
    logic [AW-1:0]     head_q, head_d, wr_addr, rd_idx;
    logic              wr_en, upd_q, upd_d, ovf_q, ovf_d;
    logic [CODE_W-1:0] rd_q, rd_d;

    assign empty = (len_q == '0);
    assign full  = (len_q == LEN_FULL);

    always_comb begin
        len_d   = len_q;
        head_d  = head_q;
        wr_en   = 1'b0;
        wr_addr = head_q + len_q[AW-1:0];
        upd_d   = 1'b0;
        ovf_d   = 1'b0;
        if (press[2]) begin
            len_d  = '0;
            head_d = '0;
            upd_d  = 1'b1;
        end else if (press[1]) begin
            if (!empty) begin
                len_d = len_q - (AW+1)'(1);
                upd_d = 1'b1;
            end
        end else if (press[0]) begin
            if (!full) begin
                wr_en = 1'b1;
                len_d = len_q + (AW+1)'(1);
                upd_d = 1'b1;
            end else begin
`ifdef SCROLL_MSG_WRAP_EN
                wr_en   = 1'b1;
                wr_addr = head_q;
                head_d  = head_q + AW'(1);
                upd_d   = 1'b1;
`else
                ovf_d   = 1'b1;
`endif
            end
        end
    end

    assign rd_idx = head_q + rd_addr;

    // Write-first bypass so a read of the slot being written returns the new code.
    always_comb begin
        rd_d = '0;
        if ({1'b0, rd_addr} < len_q) begin
            rd_d = (wr_en && (wr_addr == rd_idx)) ? char_code : mem[rd_idx];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) mem[wr_addr] <= char_code;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            len_q  <= '0;
            head_q <= '0;
            rd_q   <= '0;
            upd_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            len_q  <= len_d;
            head_q <= head_d;
            rd_q   <= rd_d;
            upd_q  <= upd_d;
            ovf_q  <= ovf_d;
        end
    end

    assign rd_data  = rd_q;
    assign msg_len  = len_q;
    assign msg_upd  = upd_q;
    assign overflow = ovf_q;

endmodule
